// File: rtl/decode_stage.sv
// Decode stage buffer: classifies the opcode, extends the immediate and holds decoded entries for execute.
// Optional macro DECODE_SKID_EN selects a two-entry skid buffer with registered in_ready; otherwise single entry.

package decode_stage_pkg;

    typedef enum logic [2:0] {
        I_IMM = 3'd0,
        S_IMM = 3'd1,
        B_IMM = 3'd2,
        U_IMM = 3'd3,
        J_IMM = 3'd4
    } imm_encoding_format_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [31:0]          inst;
        logic [31:0]          pc;
        imm_encoding_format_t fmt;
        logic                 has_imm;
        logic [31:0]          imm;
        logic                 illegal;
    } dec_entry_t;

endpackage

module imm_extender
    import decode_stage_pkg::*;
(
    input  logic [31:7]          inst_i,
    input  imm_encoding_format_t fmt_i,
    output logic [31:0]          imm_o
);

    // Reassemble and sign-extend the immediate bits for each encoding format
    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            I_IMM:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            S_IMM:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            B_IMM:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            U_IMM:   imm_o = {inst_i[31:12], 12'd0};
            J_IMM:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc,
    output imm_encoding_format_t out_fmt,
    output logic                 out_has_imm,
    output logic [31:0]          out_imm,
    output logic                 out_illegal
);

    buf_state_t           state_q;
    buf_state_t           state_d;
    dec_entry_t           dec_s;
    dec_entry_t           out_q;
    imm_encoding_format_t dec_fmt_s;
    logic                 dec_has_imm_s;
    logic                 dec_illegal_s;
    logic [31:0]          ext_imm_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 load_out_in_s;
`ifdef DECODE_SKID_EN
    dec_entry_t           skid_q;
    logic                 in_ready_q;
    logic                 load_skid_s;
    logic                 load_out_skid_s;
`endif

    // Opcode classification into immediate format, immediate presence and legality
    always_comb begin
        dec_fmt_s     = I_IMM;
        dec_has_imm_s = 1'b0;
        dec_illegal_s = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt_s     = I_IMM;
                dec_has_imm_s = 1'b1;
            end
            7'b0100011: begin
                dec_fmt_s     = S_IMM;
                dec_has_imm_s = 1'b1;
            end
            7'b1100011: begin
                dec_fmt_s     = B_IMM;
                dec_has_imm_s = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt_s     = U_IMM;
                dec_has_imm_s = 1'b1;
            end
            7'b1101111: begin
                dec_fmt_s     = J_IMM;
                dec_has_imm_s = 1'b1;
            end
            7'b0110011: begin
                dec_fmt_s     = I_IMM;
                dec_has_imm_s = 1'b0;
            end
            default: begin
                dec_fmt_s     = I_IMM;
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    imm_extender u_imm_extender (
        .inst_i (in_inst[31:7]),
        .fmt_i  (dec_fmt_s),
        .imm_o  (ext_imm_s)
    );

    // Assemble the decoded entry; R-type and illegal opcodes carry a zero immediate
    always_comb begin
        dec_s.inst    = in_inst;
        dec_s.pc      = in_pc;
        dec_s.fmt     = dec_fmt_s;
        dec_s.has_imm = dec_has_imm_s;
        dec_s.imm     = dec_has_imm_s ? ext_imm_s : 32'd0;
        dec_s.illegal = dec_illegal_s;
    end

`ifdef DECODE_SKID_EN
    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any concurrent accept or pop
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
`ifdef DECODE_SKID_EN
                    if (accept_s && !pop_s) begin
                        state_d = ST_FULL;
                    end else if (!accept_s && pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
`else
                    if (!accept_s && pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
`endif
                end
                ST_FULL:  state_d = pop_s ? ST_ONE : ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath load controls derived from the current state and handshakes
    always_comb begin
        load_out_in_s   = 1'b0;
`ifdef DECODE_SKID_EN
        load_skid_s     = 1'b0;
        load_out_skid_s = 1'b0;
`endif
        if (flush) begin
            load_out_in_s = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: load_out_in_s = accept_s;
                ST_ONE: begin
                    load_out_in_s = accept_s && pop_s;
`ifdef DECODE_SKID_EN
                    load_skid_s   = accept_s && !pop_s;
`endif
                end
`ifdef DECODE_SKID_EN
                ST_FULL:  load_out_skid_s = pop_s;
`endif
                default:  load_out_in_s = 1'b0;
            endcase
        end
    end

    // Output entry register; holds whenever execute stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (load_out_in_s) begin
            out_q <= dec_s;
`ifdef DECODE_SKID_EN
        end else if (load_out_skid_s) begin
            out_q <= skid_q;
`endif
        end
    end

`ifdef DECODE_SKID_EN
    // Skid entry and registered ready, which look only at next state so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (load_skid_s) begin
                skid_q <= dec_s;
            end
            in_ready_q <= (state_d != ST_FULL);
        end
    end
`endif

    assign out_inst    = out_q.inst;
    assign out_pc      = out_q.pc;
    assign out_fmt     = out_q.fmt;
    assign out_has_imm = out_q.has_imm;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule
